fsk_tone_demod: RTL
===================

Name: fsk_tone_demod

Overview:
- Receive-side FSK tone demodulator; the receive end of the tones and bit clock produced by the system clock generator.
- Samples the 1-bit received FSK waveform on mainclk and counts its rising edges over a fixed bit window of BIT_CYCLES mainclk cycles.
- A high edge count decodes as 1 (clk2-rate tone); a low count decodes as 0 (clk32-rate tone).
- Also reports carrier presence.
- Sits between the line input and the frame/byte assembler.

Parameters:
- BIT_CYCLES, 576: mainclk cycles per bit window (one full clk288 period).
- THRESH, 77: edge count at or above which the bit is 1.
- MIN_EDGES, 4: minimum edges per window for the window to count as "good".
- CNT_W, 10: edge counter width; the counter saturates at 2^CNT_W-1.

Ports:
- mainclk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- fsk_in, input, 1: received FSK waveform, asynchronous to mainclk.
- bit_out, output, 1: decoded bit, held until the next valid window.
- bit_valid, output, 1: one-cycle pulse when bit_out is updated.
- carrier_ok, output, 1: high while the state is LOCKED.
- edge_count, output, CNT_W: edge count latched for the last completed window (debug).

Behaviour:
- Reset (reset=0, async): all state and outputs go to 0, and the state goes to NO_CARRIER. This covers bit_out, bit_valid, carrier_ok, edge_count, the window counter, the edge counter, the good-window counter and the synchronizer flops.
- Synchronizer: 2-flop sync of fsk_in, then a rising-edge detect (s2 & ~s3). An edge is seen 3 cycles after the fsk_in transition.
- Window counter:
  - Counts 0..BIT_CYCLES-1 and wraps to 0.
  - Free-running from reset release; no realignment.
- Edge counter:
  - Increments on each detected edge and saturates.
  - At window end (window counter == BIT_CYCLES-1), the edge of that same cycle is included.
  - At window end, the total goes to edge_count and the counter restarts at 0, or at 1 if an edge also occurs in the first cycle of the next window.
- Window classification at window end:
  - good = total ≥ MIN_EDGES.
  - bit = (total ≥ THRESH).
- State machine, evaluated at window end only:
  - NO_CARRIER: good → LOCKING; bad → stay.
  - LOCKING: good → LOCKED; bad → NO_CARRIER.
  - LOCKED: good → stay; bad → NO_CARRIER.
- Outputs:
  - If the next state is LOCKED and the window is good, bit_out <= bit and bit_valid <= 1 on the cycle after window end. The first decoded bit therefore comes from the 2nd consecutive good window.
  - bit_valid is 0 in all other cycles.
  - carrier_ok follows the registered state (LOCKED) and updates on the same cycle as bit_valid.
  - On a bad window, carrier_ok drops and bit_out holds its last value.
- Latency: window end → bit_valid = 1 cycle; fsk_in edge → counted = 3 cycles.
- Reset mid-window: the partial count is discarded and decoding restarts from NO_CARRIER.
- Constant fsk_in (0 or 1): 0 edges, so the window is bad.

Optional Feature:
- FSK_DEMOD_GLITCH_FILTER_EN defined:
  - Adds a third sync stage.
  - A rising edge counts only if the new level holds for 2 consecutive samples (s2=s3=1 after s4=0).
  - 1-cycle high pulses are rejected.
  - Edge latency becomes 4 cycles.
- Undefined: plain 2-flop sync and edge detect as above.

Decomposition:
- Shared package/include fsk_pkg holds:
  - constants BIT_CYCLES=576, TONE1_PERIOD=4, TONE0_PERIOD=64, THRESH, MIN_EDGES;
  - state encodings NO_CARRIER=2'd0, LOCKING=2'd1, LOCKED=2'd2.
- One sub-module: fsk_edge_sync. It contains the synchronizer, the edge detect and the optional glitch filter, and outputs a 1-cycle edge pulse.

Test Plan:
- Square wave with period 4 (144 edges/window): edge_count=144; bit_valid at the end of window 2 with bit_out=1; carrier_ok=1 from then on.
- Period 64 (9 edges/window) after lock: bit_out=0 each window; carrier_ok stays 1.
- Threshold boundary: period 7 (82 edges) → bit_out=1; period 8 (72 edges) → bit_out=0.
- fsk_in held 0 for one window while LOCKED: carrier_ok=0, no bit_valid, bit_out unchanged. Tone restored: first bit_valid after 2 good windows.
- Assert reset at cycle 300 of a window: all outputs 0 immediately. After release, lock takes 2 full windows.
- With FSK_DEMOD_GLITCH_FILTER_EN: inject 20 one-cycle pulses into a period-64 tone → edge_count stays 9. Without the macro → 29.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared constants, state encoding and window-result payload for the FSK
// tone demodulator.
package fsk_pkg;

    localparam int unsigned BIT_CYCLES   = 576;  // mainclk cycles per bit window
    localparam int unsigned TONE1_PERIOD = 4;    // clk2-rate tone, decodes as 1
    localparam int unsigned TONE0_PERIOD = 64;   // clk32-rate tone, decodes as 0
    localparam int unsigned THRESH       = 77;   // edges >= THRESH decode as 1
    localparam int unsigned MIN_EDGES    = 4;    // edges >= MIN_EDGES mean a good window
    localparam int unsigned CNT_W        = 10;   // saturating edge counter width
    localparam int unsigned WIN_W        = $clog2(BIT_CYCLES);

    typedef enum logic [1:0] {
        NO_CARRIER = 2'd0,
        LOCKING    = 2'd1,
        LOCKED     = 2'd2
    } fsk_state_e;

    // Classification of the window that ends on the current cycle.
    typedef struct packed {
        logic             bit_val;
        logic             good;
        logic [CNT_W-1:0] total;
    } win_result_t;

endpackage

// File: rtl/fsk_edge_sync.sv
// Synchronizes the asynchronous FSK input and produces a one-cycle pulse per
// rising edge.
// Optional macro FSK_DEMOD_GLITCH_FILTER_EN: adds a stage and only accepts a
// rising edge whose new level holds for two samples (edge latency 4 cycles
// instead of 3; single-cycle high pulses are rejected).
// Ports:
//   clk_i     system clock (mainclk)
//   rst_ni    asynchronous active-low reset
//   fsk_i     raw FSK line input
//   edge_o_c  combinational rising-edge pulse from registered sync stages
module fsk_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic fsk_i,
    output logic edge_o_c
);

`ifdef FSK_DEMOD_GLITCH_FILTER_EN
    localparam int unsigned STAGES = 4;
`else
    localparam int unsigned STAGES = 3;
`endif

    // sync_q[0] is s1, sync_q[1] is s2, ...
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin : sync_reg
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], fsk_i};
        end
    end

`ifdef FSK_DEMOD_GLITCH_FILTER_EN
    // High must persist for two samples after a low.
    assign edge_o_c = sync_q[1] & sync_q[2] & ~sync_q[3];
`else
    assign edge_o_c = sync_q[1] & ~sync_q[2];
`endif

endmodule

// File: rtl/fsk_tone_demod.sv
// FSK tone demodulator: counts synchronized rising edges of the line input
// over fixed BIT_CYCLES windows, decodes high counts as 1 and low counts as 0,
// and tracks carrier lock across consecutive good windows.
// Optional macro FSK_DEMOD_GLITCH_FILTER_EN: see fsk_edge_sync.
// Ports:
//   mainclk     system clock, rising edge
//   reset       asynchronous active-low reset
//   fsk_in      received FSK waveform (asynchronous)
//   bit_out     decoded bit, held until the next valid window
//   bit_valid   one-cycle pulse when bit_out updates
//   carrier_ok  high while locked
//   edge_count  edge total of the last completed window
module fsk_tone_demod
    import fsk_pkg::*;
(
    input  logic             mainclk,
    input  logic             reset,
    input  logic             fsk_in,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             carrier_ok,
    output logic [CNT_W-1:0] edge_count
);

    logic edge_c;

    fsk_edge_sync u_edge_sync (
        .clk_i    (mainclk),
        .rst_ni   (reset),
        .fsk_i    (fsk_in),
        .edge_o_c (edge_c)
    );

    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    fsk_state_e       state_q, state_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             carrier_q, carrier_d;
    logic             win_end_c;
    win_result_t      win_c;

    // Window total including an edge on the final cycle, with saturation.
    always_comb begin : window_eval
        win_c     = '0;
        win_end_c = (win_q == WIN_W'(BIT_CYCLES - 1));
        win_c.total = cnt_q;
        if (edge_c && (cnt_q != {CNT_W{1'b1}})) begin
            win_c.total = cnt_q + CNT_W'(1);
        end
        win_c.good    = (win_c.total >= CNT_W'(MIN_EDGES));
        win_c.bit_val = (win_c.total >= CNT_W'(THRESH));
    end

    // Next-state and output logic; the lock FSM only moves at window end.
    always_comb begin : next_state
        win_d        = win_q + WIN_W'(1);
        cnt_d        = win_c.total;
        edge_count_d = edge_count_q;
        state_d      = state_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;

        if (win_end_c) begin
            win_d        = '0;
            cnt_d        = '0;
            edge_count_d = win_c.total;
            case (state_q)
                NO_CARRIER: state_d = win_c.good ? LOCKING : NO_CARRIER;
                LOCKING:    state_d = win_c.good ? LOCKED  : NO_CARRIER;
                LOCKED:     state_d = win_c.good ? LOCKED  : NO_CARRIER;
                default:    state_d = NO_CARRIER;
            endcase
            if ((state_d == LOCKED) && win_c.good) begin
                bit_out_d   = win_c.bit_val;
                bit_valid_d = 1'b1;
            end
        end

        carrier_d = (state_d == LOCKED);
    end

    always_ff @(posedge mainclk or negedge reset) begin : state_reg
        if (!reset) begin
            win_q        <= '0;
            cnt_q        <= '0;
            edge_count_q <= '0;
            state_q      <= NO_CARRIER;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            carrier_q    <= 1'b0;
        end else begin
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            edge_count_q <= edge_count_d;
            state_q      <= state_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            carrier_q    <= carrier_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign carrier_ok = carrier_q;
    assign edge_count = edge_count_q;

endmodule
